// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, counter width
// and the default gate length (1 s at a 50 MHz system clock).
package freq_meter_pkg;

  localparam int CNT_W               = 32;
  localparam int DEFAULT_GATE_CYCLES = 50_000_000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a history flop;
// rise is a one-cycle pulse on each synchronized 0->1 transition.
module sig_sync_edge (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// GATE_CYCLES sys_clk cycles and publishes the count with a valid pulse.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] fre,
  output logic             fre_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_e            state_q,     state_d;
  logic [GATE_W-1:0] gate_cnt_q,  gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q,  edge_cnt_d;
  logic              ovf_q,       ovf_d;
  logic [CNT_W-1:0]  fre_q,       fre_d;
  logic              ovf_out_q,   ovf_out_d;
  logic              fre_valid_q, fre_valid_d;
  logic              rise;

  sig_sync_edge u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (sig_in),
    .rise      (rise)
  );

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    fre_d       = fre_q;
    ovf_out_d   = ovf_out_q;
    fre_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = ST_GATE;
        end
      end

      ST_GATE: begin
        // Saturate instead of wrapping; an edge that would exceed max sets the flag.
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + 1'b1;
        end
        // Result is captured on the last gate cycle so it includes that cycle's edge
        // and is already stable while fre_valid is high in DONE.
        if (gate_cnt_q == GATE_LAST) begin
          state_d     = ST_DONE;
          fre_d       = edge_cnt_d;
          ovf_out_d   = ovf_d;
          fre_valid_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (continuous) begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = ST_GATE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      fre_q       <= '0;
      ovf_out_q   <= 1'b0;
      fre_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      fre_q       <= fre_d;
      ovf_out_q   <= ovf_out_d;
      fre_valid_q <= fre_valid_d;
    end
  end

  assign fre       = fre_q;
  assign overflow  = ovf_out_q;
  assign fre_valid = fre_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate window.
module tb_freq_meter;

  localparam int GATE = 100;

  logic        clk;
  logic        sys_rst_n;
  logic        sig_in;
  logic        start;
  logic        continuous;
  logic [31:0] fre;
  logic        fre_valid;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int sig_period = 0;
  int last_period = 0;
  int sig_phase = 0;

  freq_meter #(.GATE_CYCLES(GATE)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .fre        (fre),
    .fre_valid  (fre_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // periodic sig_in: high for period/2 cycles, low for the rest; 0 when period==0
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sig_period != last_period) begin
        last_period = sig_period;
        sig_phase   = 0;
      end
      if (sig_period == 0) begin
        sig_in = 1'b0;
      end else begin
        sig_in    = (sig_phase < sig_period / 2);
        sig_phase = (sig_phase + 1) % sig_period;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!fre_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic count_valids(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (fre_valid) pulses++;
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n;
  int pulses;

  initial begin
    sys_rst_n  = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    #1;
    chk("rst_fre", fre, 32'd0);
    chk("rst_valid", {31'd0, fre_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    idle(3);
    sys_rst_n = 1'b1;

    // single measurement, period 10
    sig_period = 10;
    idle($urandom_range(20, 30));
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    chk("t1_busy_gate", {31'd0, busy}, 32'd1);
    wait_valid(300, n);
    chk("t1_latency", n + 1, GATE + 1);
    chk("t1_fre", fre, 32'd10);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    step();
    chk("t1_valid_once", {31'd0, fre_valid}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_fre_hold", fre, 32'd10);

    // sig_in held low
    sig_period = 0;
    idle(10);
    pulse_start();
    wait_valid(300, n);
    chk("t2_latency", n + 1, GATE + 1);
    chk("t2_fre", fre, 32'd0);
    step();
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    count_valids(50, pulses);
    chk("t2_no_extra_valid", pulses, 32'd0);

    // continuous mode, period 4, with a stray start mid-gate
    sig_period = 4;
    idle($urandom_range(20, 30));
    continuous = 1'b1;
    step();
    chk("t3_busy", {31'd0, busy}, 32'd1);
    wait_valid(300, n);
    chk("t3_first_latency", n + 1, GATE + 1);
    chk("t3_fre1", fre, 32'd25);
    n = 0;
    do begin
      step();
      n++;
      start = (n == 50);
    end while (!fre_valid && n < 300);
    start = 1'b0;
    chk("t3_interval2", n, GATE + 1);
    chk("t3_fre2", fre, 32'd25);
    n = 0;
    do begin
      step();
      n++;
      if (n == 30) continuous = 1'b0;
    end while (!fre_valid && n < 300);
    chk("t3_interval3", n, GATE + 1);
    chk("t3_fre3", fre, 32'd25);
    step();
    chk("t3_idle_after", {31'd0, busy}, 32'd0);
    count_valids(120, pulses);
    chk("t3_stopped", pulses, 32'd0);

    // saturation: force the edge counter near max mid-gate, period 2
    sig_period = 2;
    idle(20);
    pulse_start();
    idle(50);
    force dut.edge_cnt_q = 32'hFFFF_FFF0;
    @(negedge clk);
    release dut.edge_cnt_q;
    wait_valid(300, n);
    chk("t4_valid_seen", {31'd0, fre_valid}, 32'd1);
    chk("t4_fre_sat", fre, 32'hFFFF_FFFF);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    step();
    chk("t4_ovf_hold", {31'd0, overflow}, 32'd1);
    chk("t4_fre_hold", fre, 32'hFFFF_FFFF);

    // asynchronous reset mid-gate
    sig_period = 10;
    idle(20);
    pulse_start();
    idle(49);
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_fre", fre, 32'd0);
    chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_rst_valid", {31'd0, fre_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    idle(2);
    sys_rst_n = 1'b1;
    count_valids(150, pulses);
    chk("t5_no_valid", pulses, 32'd0);
    chk("t5_idle_wait", {31'd0, busy}, 32'd0);
    pulse_start();
    wait_valid(300, n);
    chk("t5_latency", n + 1, GATE + 1);
    chk("t5_fre", fre, 32'd10);
    chk("t5_ovf_clear", {31'd0, overflow}, 32'd0);

    // edges only outside the gate
    sig_period = 4;
    idle(30);
    sig_period = 0;
    idle(6);
    pulse_start();
    wait_valid(300, n);
    chk("t6_latency", n + 1, GATE + 1);
    chk("t6_fre", fre, 32'd0);
    sig_period = 4;
    count_valids(60, pulses);
    chk("t6_no_valid", pulses, 32'd0);
    chk("t6_fre_hold", fre, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000_000, number of sys_clk cycles in one gate window (1 s at 50 MHz, so the result is in Hz).
REQ-002 Port sys_clk, input, 1, single clock for all logic.
REQ-003 Port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port sig_in, input, 1, signal under measurement, asynchronous to sys_clk.
REQ-005 Port start, input, 1, single-cycle request for one measurement (driven from key_flag).
REQ-006 Port continuous, input, 1, level; when high, a new gate starts immediately after each result.
REQ-007 Port fre, output, 32, last measured rising-edge count per gate (unsigned binary, feeds bcd_32).
REQ-008 Port fre_valid, output, 1, one-cycle pulse when fre updates.
REQ-009 Port overflow, output, 1, asserted with fre when the count saturated.
REQ-010 Port busy, output, 1, high while a gate window is open or a result is pending.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is synchronizer output 1 with history 0.
REQ-012 FSM states SHALL be IDLE, GATE and DONE.
REQ-013 IDLE: if start or continuous is high, the FSM SHALL clear the gate counter, the edge counter and the overflow flag, then enter GATE next cycle.
REQ-014 GATE SHALL last exactly GATE_CYCLES cycles, with the gate counter running 0..GATE_CYCLES-1.
REQ-015 In GATE, each detected rising edge SHALL increment the edge counter by 1, including an edge on the last gate cycle.
REQ-016 Edges detected outside GATE SHALL NOT be counted.
REQ-017 The edge counter SHALL saturate at 32'hFFFF_FFFF and set the internal overflow flag, never wrapping.
REQ-018 After the last gate cycle, the FSM SHALL enter DONE for one cycle.
REQ-019 In DONE, the block SHALL register fre = edge counter and overflow = flag, and pulse fre_valid for exactly that cycle.
REQ-020 From DONE, the FSM SHALL go to GATE if continuous is high (counters cleared, same as REQ-013), otherwise to IDLE.
REQ-021 Latency: start sampled high in IDLE at cycle T gives GATE in cycles T+1..T+GATE_CYCLES and fre_valid at T+GATE_CYCLES+1.
REQ-022 A start pulse while busy SHALL be ignored and not queued.
REQ-023 fre and overflow SHALL hold their values between fre_valid pulses.
REQ-024 busy SHALL be high in GATE and DONE, and low in IDLE.
REQ-025 Deassertion of continuous mid-gate SHALL NOT abort the current gate; the FSM returns to IDLE after its DONE.
REQ-026 Minimum measurable input period is 2 sys_clk cycles; faster inputs give an undefined count (not checked).

Reset
REQ-027 On sys_rst_n low, the block SHALL asynchronously set FSM=IDLE, all counters=0, synchronizer/history flops=0, fre=0, fre_valid=0, overflow=0, busy=0.
REQ-028 Reset mid-gate SHALL discard the partial count with no fre_valid pulse; after release the FSM waits in IDLE for start/continuous.

Structure
REQ-029 Shared package freq_meter_pkg SHALL hold the state encoding, counter width (32) and the default GATE_CYCLES.
REQ-030 Synchronizer and edge detect SHALL be one sub-module, sig_sync_edge (ports sys_clk, sys_rst_n, din, rise).
REQ-031 Gate counter width SHALL be sized from GATE_CYCLES.

Verification (GATE_CYCLES=100 in simulation)
REQ-032 sig_in period 10 clks, start pulse -> fre_valid exactly 101 cycles after start, fre=10, overflow=0.
REQ-033 sig_in held at 0, start -> fre=0, fre_valid pulses once, busy low the cycle after.
REQ-034 continuous=1, sig_in period 4 clks -> fre_valid every 101 cycles, fre=25 each time; second start pulse mid-gate has no effect.
REQ-035 sig_in period 2 clks with edge counter forced to 32'hFFFF_FFF0 mid-gate -> fre=32'hFFFF_FFFF, overflow=1.
REQ-036 sys_rst_n pulsed low at gate cycle 50 -> all outputs 0 immediately, no fre_valid; next start measures a full 100-cycle gate.
REQ-037 Edges applied only before start and after the DONE cycle -> fre=0.
